rx_symbol_lock_ctrl: RTL and testbench

RX_SYMBOL_LOCK_CTRL -- requirements
Module: rx_symbol_lock_ctrl

---
 rtl/rx_symbol_lock_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_rx_symbol_lock_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_symbol_lock_ctrl.sv
// rx_symbol_lock_ctrl
//   Symbol alignment controller for a 10-bit line code. data_in is a sliding
//   10-bit window that advances one bit per clk. A comma in the window anchors
//   a word boundary. Commas that keep recurring exactly 10 clks apart build
//   confidence until lock is declared. Once locked, one aligned symbol is
//   delivered per word boundary.
//
// Ports
//   clk         recovered bit clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      alignment enable; low forces SEARCH
//   data_in     sliding 10-bit window
//   rx_data     aligned symbol, updated with word_strobe
//   word_strobe one-clk pulse per delivered symbol
//   rx_valid    high while locked, qualifies rx_data
//   comma_pulse one-clk pulse when the delivered symbol is a comma
//   locked      symbol lock status
//   state       FSM state: 0 SEARCH, 1 CHECK, 2 LOCKED
module rx_symbol_lock_ctrl #(
  parameter logic [9:0]  COMMA_P       = 10'h0FA,
  parameter logic [9:0]  COMMA_N       = 10'h305,
  parameter int unsigned LOCK_CNT      = 4,
  parameter int unsigned ERR_LIMIT     = 3,
  parameter int unsigned TIMEOUT_WORDS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [9:0] data_in,
  output logic [9:0] rx_data,
  output logic       word_strobe,
  output logic       rx_valid,
  output logic       comma_pulse,
  output logic       locked,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } st_t;

  localparam logic [3:0] LOCK_CNT_L  = 4'(LOCK_CNT);
  localparam logic [3:0] ERR_LIMIT_L = 4'(ERR_LIMIT);
  localparam logic [7:0] TIMEOUT_L   = 8'(TIMEOUT_WORDS);

  st_t        st_p0, st_nxt;
  logic [3:0] phase_p0, phase_nxt;
  logic [3:0] good_p0, good_nxt;
  logic [3:0] err_p0, err_nxt;
  logic [7:0] word_p0, word_nxt;
  logic [9:0] rx_data_p0, rx_data_nxt;
  logic       strobe_p0, strobe_nxt;
  logic       cp_p0, cp_nxt;
  logic       locked_p0;

  logic       is_comma;
  logic       boundary;
  logic [3:0] phase_inc;
  logic [3:0] good_inc;
  logic [3:0] err_inc;
  logic [7:0] word_inc;

  assign is_comma  = (data_in == COMMA_P) || (data_in == COMMA_N);
  // phase 9 marks the edge exactly 10 clks after the anchoring edge
  assign boundary  = (phase_p0 == 4'd9);
  assign phase_inc = boundary ? 4'd0 : phase_p0 + 4'd1;
  assign good_inc  = good_p0 + 4'd1;
  assign err_inc   = err_p0 + 4'd1;
  assign word_inc  = word_p0 + 8'd1;

  always_comb begin
    st_nxt      = st_p0;
    phase_nxt   = phase_p0;
    good_nxt    = good_p0;
    err_nxt     = err_p0;
    word_nxt    = word_p0;
    rx_data_nxt = rx_data_p0;
    strobe_nxt  = 1'b0;
    cp_nxt      = 1'b0;

    if (!enable) begin
      st_nxt    = SEARCH;
      phase_nxt = 4'd0;
      good_nxt  = 4'd0;
      err_nxt   = 4'd0;
      word_nxt  = 8'd0;
    end else begin
      unique case (st_p0)
        SEARCH: begin
          phase_nxt = 4'd0;
          if (is_comma) begin
            st_nxt   = CHECK;
            good_nxt = 4'd1;
            word_nxt = 8'd0;
          end
        end

        CHECK: begin
          phase_nxt = phase_inc;
          if (boundary) begin
            if (is_comma) begin
              good_nxt = good_inc;
              word_nxt = 8'd0;
              if (good_inc == LOCK_CNT_L) begin
                // the locking comma is the first delivered symbol
                st_nxt      = LOCKED;
                err_nxt     = 4'd0;
                rx_data_nxt = data_in;
                strobe_nxt  = 1'b1;
                cp_nxt      = 1'b1;
              end
            end else begin
              word_nxt = word_inc;
              if (word_inc == TIMEOUT_L) begin
                st_nxt    = SEARCH;
                phase_nxt = 4'd0;
                good_nxt  = 4'd0;
                err_nxt   = 4'd0;
                word_nxt  = 8'd0;
              end
            end
          end else if (is_comma) begin
            // misaligned comma: trust the newest one and restart the count
            phase_nxt = 4'd0;
            good_nxt  = 4'd1;
            word_nxt  = 8'd0;
          end
        end

        LOCKED: begin
          phase_nxt = phase_inc;
          if (boundary) begin
            rx_data_nxt = data_in;
            strobe_nxt  = 1'b1;
            cp_nxt      = is_comma;
            if (is_comma) err_nxt = 4'd0;
          end else if (is_comma) begin
            // lock is never re-anchored; too many stray commas drop it
            err_nxt = err_inc;
            if (err_inc == ERR_LIMIT_L) begin
              st_nxt    = SEARCH;
              phase_nxt = 4'd0;
              good_nxt  = 4'd0;
              err_nxt   = 4'd0;
              word_nxt  = 8'd0;
            end
          end
        end

        default: begin
          st_nxt    = SEARCH;
          phase_nxt = 4'd0;
          good_nxt  = 4'd0;
          err_nxt   = 4'd0;
          word_nxt  = 8'd0;
        end
      endcase
    end
  end

  // ---- register stage p0 ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_p0      <= SEARCH;
      phase_p0   <= 4'd0;
      good_p0    <= 4'd0;
      err_p0     <= 4'd0;
      word_p0    <= 8'd0;
      rx_data_p0 <= 10'h000;
      strobe_p0  <= 1'b0;
      cp_p0      <= 1'b0;
      locked_p0  <= 1'b0;
    end else begin
      st_p0      <= st_nxt;
      phase_p0   <= phase_nxt;
      good_p0    <= good_nxt;
      err_p0     <= err_nxt;
      word_p0    <= word_nxt;
      rx_data_p0 <= rx_data_nxt;
      strobe_p0  <= strobe_nxt;
      cp_p0      <= cp_nxt;
      locked_p0  <= (st_nxt == LOCKED);
    end
  end

  assign state       = st_p0;
  assign rx_data     = rx_data_p0;
  assign word_strobe = strobe_p0;
  assign comma_pulse = cp_p0;
  assign locked      = locked_p0;
  assign rx_valid    = locked_p0;

endmodule

// File: tb/tb_rx_symbol_lock_ctrl.sv
module tb_rx_symbol_lock_ctrl;

  localparam logic [9:0] CP   = 10'h0FA;
  localparam logic [9:0] CN   = 10'h305;
  localparam int         LOCK = 4;
  localparam int         EL   = 3;
  localparam int         TO   = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] data_in = 10'h000;
  logic [9:0] rx_data;
  logic       word_strobe, rx_valid, comma_pulse, locked;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: boundaries are found by distance from the anchor cycle
  int         cyc = 0;
  int         m_state = 0;
  int         m_anchor = 0;
  int         m_good = 0;
  int         m_words = 0;
  int         m_errs = 0;
  logic [9:0] m_rxd = 10'h000;
  logic       m_strobe = 1'b0;
  logic       m_cp = 1'b0;

  always #5 clk = ~clk;

  rx_symbol_lock_ctrl #(
    .COMMA_P(CP), .COMMA_N(CN), .LOCK_CNT(LOCK), .ERR_LIMIT(EL), .TIMEOUT_WORDS(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in),
    .rx_data(rx_data), .word_strobe(word_strobe), .rx_valid(rx_valid),
    .comma_pulse(comma_pulse), .locked(locked), .state(state)
  );

  function automatic logic [9:0] filler();
    logic [9:0] v;
    v = 10'($urandom);
    if (v == CP || v == CN) v = v ^ 10'h001;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_good = 0; m_words = 0; m_errs = 0;
    m_rxd = 10'h000; m_strobe = 1'b0; m_cp = 1'b0;
  endtask

  task automatic model_clear();
    m_state = 0; m_good = 0; m_words = 0; m_errs = 0;
  endtask

  task automatic model_step(input logic en, input logic [9:0] d);
    logic comma, bnd;
    cyc++;
    comma = (d == CP) || (d == CN);
    bnd = (m_state != 0) && (((cyc - m_anchor) % 10) == 0);
    m_strobe = 1'b0;
    m_cp = 1'b0;
    if (!en) begin
      model_clear();
    end else if (m_state == 0) begin
      if (comma) begin
        m_state = 1; m_anchor = cyc; m_good = 1; m_words = 0;
      end
    end else if (m_state == 1) begin
      if (bnd && comma) begin
        m_good++; m_words = 0;
        if (m_good == LOCK) begin
          m_state = 2; m_errs = 0; m_rxd = d; m_strobe = 1'b1; m_cp = 1'b1;
        end
      end else if (bnd) begin
        m_words++;
        if (m_words == TO) model_clear();
      end else if (comma) begin
        m_anchor = cyc; m_good = 1; m_words = 0;
      end
    end else begin
      if (bnd) begin
        m_rxd = d; m_strobe = 1'b1; m_cp = comma;
        if (comma) m_errs = 0;
      end else if (comma) begin
        m_errs++;
        if (m_errs == EL) model_clear();
      end
    end
  endtask

  task automatic check_cycle();
    logic [15:0] act, req;
    act = {state, locked, rx_valid, word_strobe, comma_pulse, rx_data};
    req = {2'(m_state), (m_state == 2), (m_state == 2), m_strobe, m_cp, m_rxd};
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL cycle %0d outputs{state,locked,rx_valid,strobe,comma_pulse,rx_data} actual=%h required=%h",
               cyc, act, req);
    end
  endtask

  task automatic lit(input string name, input logic [9:0] act, input logic [9:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic stepr(input logic rn, input logic en, input logic [9:0] d);
    @(negedge clk);
    rst_n = rn;
    enable = en;
    data_in = d;
    if (!rn) model_reset();
    else model_step(en, d);
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic step(input logic en, input logic [9:0] d);
    stepr(1'b1, en, d);
  endtask

  task automatic fill(input int n);
    repeat (n) step(1'b1, filler());
  endtask

  initial begin
    // reset holds even with a comma present
    stepr(1'b0, 1'b1, CP);
    lit("reset_state", 10'(state), 10'd0);
    lit("reset_rx_data", rx_data, 10'h000);
    stepr(1'b0, 1'b1, CP);
    // enable low: a comma must not anchor
    step(1'b0, CP);
    lit("disabled_state", 10'(state), 10'd0);
    fill(3);

    // lock on four aligned commas
    step(1'b1, CP);
    lit("anchor_state", 10'(state), 10'd1);
    repeat (2) begin fill(9); step(1'b1, CP); end
    lit("pre_lock_locked", 10'(locked), 10'd0);
    fill(9); step(1'b1, CP);
    lit("lock_locked", 10'(locked), 10'd1);
    lit("lock_rx_data", rx_data, 10'h0FA);
    lit("lock_comma_pulse", 10'(comma_pulse), 10'd1);
    lit("lock_strobe", 10'(word_strobe), 10'd1);
    fill(9); step(1'b1, CN);
    lit("deliver_305", rx_data, 10'h305);
    fill(10);
    lit("filler_strobe", 10'(word_strobe), 10'd1);
    lit("filler_comma_pulse", 10'(comma_pulse), 10'd0);

    // two stray commas, aligned comma clears the error count
    fill(2); step(1'b1, CN); fill(2); step(1'b1, CN); fill(3);
    step(1'b1, CP);
    lit("errs_cleared_locked", 10'(locked), 10'd1);
    // two more strays and a comma-free boundary keep lock; third stray drops it
    fill(2); step(1'b1, CN); fill(2); step(1'b1, CN); fill(4);
    lit("two_errs_locked", 10'(locked), 10'd1);
    fill(2); step(1'b1, CN);
    lit("loss_locked", 10'(locked), 10'd0);
    lit("loss_state", 10'(state), 10'd0);

    // re-anchor on a comma 3 bits off, then lock 4 commas after the new anchor
    step(1'b1, CP); fill(9); step(1'b1, CP);
    fill(2); step(1'b1, CP);
    repeat (2) begin fill(9); step(1'b1, CP); end
    lit("reanchor_pre_state", 10'(state), 10'd1);
    fill(9); step(1'b1, CP);
    lit("reanchor_locked", 10'(locked), 10'd1);

    // enable low on a LOCKED boundary wins over the strobe
    fill(9); step(1'b0, CP);
    lit("prio_strobe", 10'(word_strobe), 10'd0);
    lit("prio_state", 10'(state), 10'd0);
    lit("prio_locked", 10'(locked), 10'd0);

    // timeout after 64 comma-free boundaries
    step(1'b1, CP);
    repeat (TO - 1) fill(10);
    lit("timeout_pre_state", 10'(state), 10'd1);
    fill(10);
    lit("timeout_state", 10'(state), 10'd0);
    lit("timeout_locked", 10'(locked), 10'd0);

    // asynchronous reset in the middle of LOCKED
    step(1'b1, CP);
    repeat (3) begin fill(9); step(1'b1, CP); end
    lit("relock_locked", 10'(locked), 10'd1);
    fill(4);
    #1 rst_n = 1'b0;
    #1;
    lit("async_state", 10'(state), 10'd0);
    lit("async_locked", 10'(locked), 10'd0);
    lit("async_rx_valid", 10'(rx_valid), 10'd0);
    lit("async_strobe", 10'(word_strobe), 10'd0);
    lit("async_comma_pulse", 10'(comma_pulse), 10'd0);
    lit("async_rx_data", rx_data, 10'h000);
    model_reset();
    stepr(1'b0, 1'b1, CP);
    fill(2);
    step(1'b1, CN);
    repeat (3) begin fill(9); step(1'b1, CN); end
    lit("after_reset_locked", 10'(locked), 10'd1);
    fill(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
